// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA display path.
//   H_ACTIVE / V_ACTIVE : visible raster size in pixels.
//   rgb12_t             : 12-bit colour, {R[3:0],G[3:0],B[3:0]}.
//   BLACK, BOX_RED      : fixed colours used by the renderers.
//   KEY_COLOR_DEF       : default transparent colour for sprite ROMs.
//   BG_COLOR_DEF        : default flat background colour.
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [11:0] rgb12_t;

   localparam rgb12_t BLACK         = 12'h000;
   localparam rgb12_t BOX_RED       = 12'hF00;
   localparam rgb12_t KEY_COLOR_DEF = 12'hF0F;
   localparam rgb12_t BG_COLOR_DEF  = 12'h777;

endpackage

// File: rtl/sprite_pos_buf.sv
// -----------------------------------------------------------------------------
// sprite_pos_buf
// Double-buffered sprite position. Writes land in a pending register and are
// copied to the active register only at frame start (falling edge of
// vsync_in), so the sprite never moves mid-frame.
// Ports:
//   clk, clr_n       : pixel clock, asynchronous active-low reset
//   vsync_in         : raw vsync from the sync generator
//   car_x, car_y     : requested sprite top-left corner
//   pos_we           : one-cycle strobe capturing car_x/car_y into pending
//   act_x, act_y     : committed position used by the renderer
//   frame_tick       : one-cycle pulse the cycle after a commit
// -----------------------------------------------------------------------------
module sprite_pos_buf
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       clr_n,
   input  logic       vsync_in,
   input  logic [9:0] car_x,
   input  logic [9:0] car_y,
   input  logic       pos_we,
   output logic [9:0] act_x,
   output logic [9:0] act_y,
   output logic       frame_tick
);

   logic [9:0] pend_x, pend_y;
   logic       pend_valid;
   logic       vsync_prev;
   logic       frame_start;
   logic       commit;

   assign frame_start = vsync_prev & ~vsync_in;
   assign commit      = frame_start & pend_valid;

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pend_x     <= '0;
         pend_y     <= '0;
         pend_valid <= 1'b0;
         act_x      <= '0;
         act_y      <= '0;
         vsync_prev <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vsync_prev <= vsync_in;
         frame_tick <= commit;
         if (commit) begin
            act_x <= pend_x;
            act_y <= pend_y;
         end
         // A write in the commit cycle wins: the old pending value commits now
         // and the new one stays pending for the next frame.
         if (pos_we) begin
            pend_x     <= car_x;
            pend_y     <= car_y;
            pend_valid <= 1'b1;
         end else if (commit) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/vga_sprite_render.sv
// -----------------------------------------------------------------------------
// vga_sprite_render
// Overlays one sprite from an external synchronous ROM onto a flat background.
// Two register stages: stage 1 does the box test and ROM address, stage 2
// picks the colour once ROM data is back. Syncs travel through the same two
// stages so colour and syncs stay aligned.
// Optional build macro: SPRITE_BOX_EN -- draws a red 1-pixel border on the
// sprite's edge pixels, overriding ROM data and key colour.
// Ports:
//   clk, clr_n               : pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y         : raster position from sync generator
//   video_on                 : visible-area flag from sync generator
//   hsync_in, vsync_in       : raw syncs from sync generator
//   car_x, car_y, pos_we     : sprite position write port
//   rom_addr / rom_data      : sprite ROM, data valid one cycle after address
//   rgb                      : {R,G,B} 4 bits each, 2-cycle latency
//   hsync, vsync             : syncs delayed 2 cycles
//   frame_tick               : pulse when a new position is committed
// -----------------------------------------------------------------------------
module vga_sprite_render
   import vga_pkg::*;
#(
   parameter int     SPRITE_W  = 32,
   parameter int     SPRITE_H  = 64,
   parameter int     ADDR_W    = 11,
   parameter rgb12_t KEY_COLOR = KEY_COLOR_DEF,
   parameter rgb12_t BG_COLOR  = BG_COLOR_DEF
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              video_on,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [9:0]        car_x,
   input  logic [9:0]        car_y,
   input  logic              pos_we,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [11:0]       rgb,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_tick
);

   // Column bits of the ROM address; SPRITE_W is a power of two so the
   // address is simply {row, column}.
   localparam int XB = $clog2(SPRITE_W);
   localparam int YB = ADDR_W - XB;

   logic [9:0] act_x, act_y;

   sprite_pos_buf u_pos_buf (
      .clk        (clk),
      .clr_n      (clr_n),
      .vsync_in   (vsync_in),
      .car_x      (car_x),
      .car_y      (car_y),
      .pos_we     (pos_we),
      .act_x      (act_x),
      .act_y      (act_y),
      .frame_tick (frame_tick)
   );

   // ---------------- stage 1: box test and ROM address ----------------------
   // 11-bit arithmetic so a sprite hanging past column 639 / row 479 is
   // clipped rather than wrapping around to the left/top edge.
   logic [10:0] dx, dy, x_end, y_end;
   logic        hit;
   logic        unused_bits;

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      dx    = {1'b0, pixel_x} - {1'b0, act_x};
      dy    = {1'b0, pixel_y} - {1'b0, act_y};
      x_end = {1'b0, act_x} + 11'(SPRITE_W);
      y_end = {1'b0, act_y} + 11'(SPRITE_H);
      hit   = video_on
            && (pixel_x >= act_x) && ({1'b0, pixel_x} < x_end)
            && (pixel_y >= act_y) && ({1'b0, pixel_y} < y_end);
   end

   // Upper difference bits are only meaningful outside the sprite, where the
   // address is forced to zero anyway.
   assign unused_bits = ^{dx[10:XB], dy[10:YB]};

   logic hit1, von1, hs1, vs1;
`ifdef SPRITE_BOX_EN
   logic edge1;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rom_addr <= '0;
         hit1     <= 1'b0;
         von1     <= 1'b0;
         hs1      <= 1'b0;
         vs1      <= 1'b0;
`ifdef SPRITE_BOX_EN
         edge1    <= 1'b0;
`endif
      end else begin
         rom_addr <= hit ? {dy[YB-1:0], dx[XB-1:0]} : '0;
         hit1     <= hit;
         von1     <= video_on;
         hs1      <= hsync_in;
         vs1      <= vsync_in;
`ifdef SPRITE_BOX_EN
         edge1    <= hit && ((dx == 11'd0) || (dx == 11'(SPRITE_W - 1))
                          || (dy == 11'd0) || (dy == 11'(SPRITE_H - 1)));
`endif
      end
   end

   // ---------------- stage 2: colour select ---------------------------------
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rgb   <= BLACK;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         hsync <= hs1;
         vsync <= vs1;
         if (!von1)
            rgb <= BLACK;
`ifdef SPRITE_BOX_EN
         else if (edge1)
            rgb <= BOX_RED;
`endif
         else if (hit1 && (rom_data != KEY_COLOR))
            rgb <= rom_data;
         else
            rgb <= BG_COLOR;
      end
   end

endmodule

// File: tb/tb_vga_sprite_render.sv
// -----------------------------------------------------------------------------
// tb_vga_sprite_render
// Directed bench for vga_sprite_render. Pixels are streamed one per clock;
// a small behavioural model of the position buffer and colour rule predicts
// rom_addr and frame_tick every cycle and rgb/hsync/vsync two cycles later.
// Hand-computed probes cover the key colour, clipping, mid-frame writes,
// commit-cycle writes and a mid-line reset. Honours SPRITE_BOX_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sprite_render;
   import vga_pkg::*;

   localparam int          SW  = 32;
   localparam int          SH  = 64;
   localparam logic [11:0] BG  = 12'h777;
   localparam logic [11:0] KEY = 12'hF0F;
`ifdef SPRITE_BOX_EN
   localparam logic [11:0] CORNER = BOX_RED;
`else
   localparam logic [11:0] CORNER = 12'h7FF;
`endif

   logic        clk = 1'b0;
   logic        clr_n = 1'b1;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [9:0]  car_x = '0, car_y = '0;
   logic        pos_we = 1'b0;
   logic [10:0] rom_addr;
   logic [11:0] rom_data, rgb;
   logic        hsync, vsync, frame_tick;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Sprite ROM: texel = address LSBs, with one transparent texel at dx=5,dy=3.
   function automatic logic [11:0] rom_at(input logic [10:0] a);
      return (a == 11'd101) ? KEY : {1'b0, a};
   endfunction

   assign rom_data = rom_at(rom_addr);

   vga_sprite_render dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .video_on   (video_on),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .car_x      (car_x),
      .car_y      (car_y),
      .pos_we     (pos_we),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .rgb        (rgb),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_tick (frame_tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------------------------
   int          m_ax = 0, m_ay = 0, m_px = 0, m_py = 0;
   bit          m_pv = 1'b0, m_pvs = 1'b0;
   bit          p_valid = 1'b0, p_hs, p_vs;
   logic [11:0] p_rgb;
   int          ticks = 0;

   task automatic model_reset();
      m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
      m_pv = 1'b0; m_pvs = 1'b0; p_valid = 1'b0;
   endtask

   function automatic void exp_pix(input int x, input int y, input bit von,
                                   output logic [11:0] c, output logic [10:0] a);
      int dx, dy;
      bit in_box;
      dx = x - m_ax;
      dy = y - m_ay;
      in_box = von && (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
      a = in_box ? 11'(dy * SW + dx) : 11'd0;
      if (!von)
         c = 12'h000;
`ifdef SPRITE_BOX_EN
      else if (in_box && (dx == 0 || dx == SW - 1 || dy == 0 || dy == SH - 1))
         c = 12'hF00;
`endif
      else if (in_box && rom_at(a) != KEY)
         c = rom_at(a);
      else
         c = BG;
   endfunction

   // Present one pixel for one clock and check everything due this cycle.
   task automatic step(input int x, input int y, input bit von, input bit hs,
                       input bit vs, input bit we);
      logic [11:0] c;
      logic [10:0] a;
      bit          tick;
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = von;
      hsync_in = hs;
      vsync_in = vs;
      pos_we   = we;
      exp_pix(x, y, von, c, a);
      tick = m_pvs && !vs && m_pv;
      if (tick) begin
         m_ax = m_px;
         m_ay = m_py;
      end
      if (we) begin
         m_px = int'(car_x);
         m_py = int'(car_y);
         m_pv = 1'b1;
      end else if (tick) begin
         m_pv = 1'b0;
      end
      m_pvs = vs;
      @(posedge clk);
      #1;
      pos_we = 1'b0;
      check("rom_addr", rom_addr, a);
      check("frame_tick", frame_tick, tick);
      if (frame_tick) ticks++;
      if (p_valid) begin
         check("rgb", rgb, p_rgb);
         check("hsync", hsync, p_hs);
         check("vsync", vsync, p_vs);
      end
      p_valid = 1'b1;
      p_rgb   = c;
      p_hs    = hs;
      p_vs    = vs;
   endtask

   task automatic set_car(input int x, input int y);
      car_x = 10'(x);
      car_y = 10'(y);
   endtask

   task automatic frame_pulse();
      step(810, 490, 0, 0, 1, 0);
      step(810, 491, 0, 0, 0, 0);
      step(810, 492, 0, 0, 0, 0);
      step(810, 493, 0, 0, 1, 0);
   endtask

   task automatic scan(input int y0, input int y1, input int x0, input int x1);
      for (int y = y0; y <= y1; y++) begin
         for (int x = x0; x <= x1; x++) step(x, y, 1, 1, 1, 0);
         step(800, y, 0, 0, 1, 0);
         step(801, y, 0, 0, 1, 0);
      end
   endtask

   // One visible pixel followed by a blank one; rgb then shows the first.
   task automatic probe(input int x, input int y, input string tag, input logic [11:0] exp);
      step(x, y, 1, 1, 1, 0);
      step(810, y, 0, 0, 1, 0);
      check(tag, rgb, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      #1 clr_n = 1'b0;
      #11;
      check("rst_rgb", rgb, 12'h000);
      check("rst_hsync", hsync, 1'b0);
      check("rst_vsync", vsync, 1'b0);
      check("rst_frame_tick", frame_tick, 1'b0);
      check("rst_rom_addr", rom_addr, 11'd0);
      @(posedge clk);
      #1 clr_n = 1'b1;

      // Commit (100,200) and scan around the sprite.
      set_car(100, 200);
      step(810, 500, 0, 0, 1, 1);
      t0 = ticks;
      frame_pulse();
      check("first_commit_ticks", 32'(ticks - t0), 32'd1);
      scan(196, 267, 96, 135);
      probe(105, 203, "key_transparent", BG);
      probe(106, 203, "tex_106_203", 12'h066);
      probe(99, 203, "left_of_box", BG);
      probe(131, 263, "corner_br", CORNER);
      probe(132, 263, "right_of_box", BG);
      probe(131, 264, "below_box", BG);

      // Clipping at the right edge.
      set_car(620, 200);
      step(810, 300, 0, 0, 1, 1);
      frame_pulse();
      scan(208, 212, 600, 639);
      scan(208, 212, 0, 15);
      probe(639, 210, "clip_x639", 12'h153);
      probe(5, 210, "nowrap_x5", BG);

      // Mid-frame write: old position holds until the next frame start.
      scan(214, 215, 618, 630);
      set_car(300, 300);
      step(625, 215, 1, 1, 1, 1);
      probe(625, 215, "old_pos_holds", 12'h1E5);
      t0 = ticks;
      frame_pulse();
      check("midframe_ticks", 32'(ticks - t0), 32'd1);
      probe(302, 301, "new_pos", 12'h022);
      probe(625, 215, "old_pos_gone", BG);

      // Write in the exact frame-start cycle.
      set_car(10, 10);
      step(810, 400, 0, 0, 1, 1);
      t0 = ticks;
      step(810, 490, 0, 0, 1, 0);
      set_car(50, 50);
      step(810, 491, 0, 0, 0, 1);
      step(810, 492, 0, 0, 0, 0);
      step(810, 493, 0, 0, 1, 0);
      probe(12, 11, "commit_old_pending", 12'h022);
      frame_pulse();
      check("collision_ticks", 32'(ticks - t0), 32'd2);
      probe(52, 51, "commit_new_pending", 12'h022);
      probe(12, 11, "old_pending_gone", BG);

      // Reset mid-line while frame_tick and syncs are high.
      set_car(200, 100);
      step(55, 55, 1, 1, 1, 1);
      step(56, 55, 1, 1, 1, 0);
      step(57, 55, 1, 1, 0, 0);
      check("pre_rst_tick", frame_tick, 1'b1);
      check("pre_rst_rgb", rgb, 12'h0A6);
      #2 clr_n = 1'b0;
      #1;
      check("async_rgb", rgb, 12'h000);
      check("async_hsync", hsync, 1'b0);
      check("async_vsync", vsync, 1'b0);
      check("async_frame_tick", frame_tick, 1'b0);
      check("async_rom_addr", rom_addr, 11'd0);
      model_reset();
      @(posedge clk);
      #1 clr_n = 1'b1;
      probe(3, 2, "origin_after_rst", 12'h043);
      set_car(20, 20);
      step(810, 400, 0, 0, 1, 1);
      t0 = ticks;
      frame_pulse();
      check("tick_after_rst", 32'(ticks - t0), 32'd1);
      probe(22, 21, "commit_after_rst", 12'h022);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_sprite_render.md
Name: vga_sprite_render

Overview:
- Downstream consumer of the VGA sync generator; runs on the same pixel-rate clock.
- Takes pixel_x, pixel_y, video_on, hsync and vsync, and overlays one player-car sprite from an external synchronous ROM onto a flat background colour.
- Drives the 12-bit RGB pins and re-timed sync pins, pipelined so colour and syncs stay aligned.
- Car position is double-buffered and committed only at frame start, so the sprite never tears.

Parameters:
- SPRITE_W, 32, sprite width in pixels; power of two, 2..64.
- SPRITE_H, 64, sprite height in pixels; 1..128.
- ADDR_W, 11, ROM address width; must hold SPRITE_W*SPRITE_H-1.
- KEY_COLOR, 12'hF0F, ROM colour treated as transparent.
- BG_COLOR, 12'h777, colour shown where no sprite pixel is drawn.

Ports:
- clk  in  1  pixel-rate clock, same clock as the sync generator.
- clr_n  in  1  asynchronous active-low reset.
- pixel_x  in  10  from sync generator.
- pixel_y  in  10  from sync generator.
- video_on  in  1  from sync generator.
- hsync_in  in  1  from sync generator.
- vsync_in  in  1  from sync generator.
- car_x  in  10  requested sprite left column.
- car_y  in  10  requested sprite top row.
- pos_we  in  1  single-cycle strobe; captures car_x/car_y into the pending register.
- rom_addr  out  ADDR_W  sprite ROM address; ROM data returns one cycle later.
- rom_data  in  12  ROM read data.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}.
- hsync  out  1  hsync_in delayed 2 cycles.
- vsync  out  1  vsync_in delayed 2 cycles.
- frame_tick  out  1  one-cycle pulse when the active position is committed.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset values: every register clears, so rgb=0, hsync=0, vsync=0, frame_tick=0, rom_addr=0, pending and active positions=0, pending_valid=0.
- A reset mid-frame blanks output immediately. The previous vsync sample also clears, so the first frame-start edge is detected normally.
- Position buffer:
  - pos_we=1 loads pending_x/pending_y and sets pending_valid.
  - Frame start is the cycle in which vsync_in=0 and its previous sample was 1.
  - At frame start, if pending_valid: active<=pending, pending_valid<=0, frame_tick=1 on the next cycle.
  - If pos_we coincides with frame start, the new value goes to pending and pending_valid stays 1. The commit uses the old pending value; the new one commits at the following frame.
  - No pending value at frame start: active position is held and there is no frame_tick.
- Stage 1 (registered):
  - dx = pixel_x - act_x and dy = pixel_y - act_y, computed at 11 bits so no term wraps.
  - hit1 = video_on & (pixel_x >= act_x) & (pixel_x < act_x+SPRITE_W) & (pixel_y >= act_y) & (pixel_y < act_y+SPRITE_H).
  - The sum comparisons are also 11-bit. A sprite partly beyond 639/479 is clipped, never wrapped.
  - rom_addr <= dy*SPRITE_W + dx, built by concatenation. If hit1=0, rom_addr <= 0.
  - von1 <= video_on; hsync and vsync are delayed one stage.
- Stage 2 (registered):
  - rgb = 0 if !von1.
  - Otherwise rgb = rom_data if hit1 and rom_data != KEY_COLOR.
  - Otherwise rgb = BG_COLOR.
- Total latency is 2 cycles, pixel-in to rgb, identical for hsync, vsync and colour.
- Pixel coordinates that wrap to large values during blanking are ignored because hit1 is gated by video_on.

Optional Feature:
- Macro: SPRITE_BOX_EN.
- When defined: sprite edge pixels (dx==0, dx==SPRITE_W-1, dy==0, dy==SPRITE_H-1) inside the visible area are forced to 12'hF00, overriding ROM and key colour. This uses one extra stage-1 edge flag; latency is unchanged.
- When undefined: no edge logic exists and output is purely ROM/background.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE=640 and V_ACTIVE=480.
  - The 12-bit colour typedef rgb12_t.
  - Colour constants BLACK, BOX_RED and the default KEY_COLOR.
- One sub-module is natural: sprite_pos_buf. It contains the pending/active registers, vsync edge detect and frame_tick. The renderer instantiates it plus its own two pipeline stages.

Test Plan:
- Reset release, car at (100,200) committed, scan the full frame with ROM data = address LSBs.
  - rgb equals BG_COLOR outside the 32x64 box and ROM data inside it.
  - rgb=0 in blanking; syncs lag inputs by exactly 2 cycles.
- ROM returns 12'hF0F at (dx=5,dy=3) -> rgb=BG_COLOR at pixel (105,203).
- Write car_x=620 -> columns 620..639 drawn, no sprite pixels at x 0..11 on the same rows (clip, no wrap).
- pos_we mid-frame with (300,300) -> old position persists to frame end; frame_tick pulses once at the next vsync falling edge, then the sprite appears at (300,300).
- pos_we asserted in the exact frame-start cycle with (50,50) while (10,10) pending -> (10,10) committed now, (50,50) one frame later, two frame_ticks.
- clr_n pulsed low mid-line -> rgb, hsync, vsync, frame_tick go 0 asynchronously; active position returns to (0,0).
- SPRITE_BOX_EN build -> border pixels 12'hF00 at dx=0/31, dy=0/63; interior unchanged.
